pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
Controller that sequences the program counter register and the instruction-memory fetch. Each cycle it computes the PC register's next value (`pc_next`): hold, sequential +4, or redirect target. It drives a req/ready handshake to instruction memory and flags valid fetched instructions to decode. It also handles halt/resume, fetch stalls, misaligned-target faults and memory-timeout faults.

Parameters:
RESET_VECTOR, 32'h0000_0000, value driven on pc_next during/after reset
TIMEOUT, 16, max cycles in WAIT before timeout fault (>=1)
TO_W, 5, width of timeout counter (must hold TIMEOUT)

Ports:
clock  in  1  system clock, posedge
reset  in  1  synchronous, active-high
pc_current  in  32  current PC register output
stall  in  1  decode back-pressure; blocks issuing new fetches
redirect_valid  in  1  branch/jump taken this cycle
redirect_target  in  32  redirect destination
halt_req  in  1  request halt after current fetch
resume  in  1  leave HALTED
imem_ready  in  1  memory completes current request
pc_next  out  32  next value for PC register (combinational)
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (= pc_current)
instr_valid  out  1  fetched instruction valid this cycle
halted  out  1  state == HALTED
fault  out  1  sticky fault
fault_cause  out  2  00 none, 01 misaligned redirect, 10 fetch timeout

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- States: IDLE, REQ, WAIT, HALTED, FAULT.
- Reset (any state, mid-fetch included):
  - state=IDLE; pending redirect cleared; timeout counter=0.
  - fault=0, cause=00, imem_req=0, instr_valid=0.
  - pc_next=RESET_VECTOR.
- IDLE: pc_next=RESET_VECTOR; go to REQ next cycle.
- REQ, stall=1: imem_req=0, pc_next=pc_current, stay in REQ.
- REQ, stall=0: imem_req=1, imem_addr=pc_current.
  - imem_ready=1 same cycle: instr_valid=1, pc_next=pc_current+4 (mod 2^32), stay in REQ.
  - imem_ready=0: go to WAIT, pc_next=pc_current.
- WAIT:
  - imem_req held 1, address stable, pc_next=pc_current.
  - Counter increments each cycle.
  - On imem_ready: instr_valid=1, pc_next=pc_current+4, counter cleared, go to REQ.
  - If counter reaches TIMEOUT without ready: go to FAULT, cause=10.
- stall during WAIT: no effect; an outstanding request always completes.
- Redirect in REQ, target aligned:
  - pc_next=redirect_target, instr_valid=0 (current fetch squashed).
  - If a ready arrives the same cycle, its data is discarded.
- Redirect in WAIT:
  - Target latched into a pending register; a later redirect overwrites it.
  - On ready: instr_valid=0, pc_next=pending target, pending cleared.
- Misaligned target (redirect_target[1:0]!=0): go to FAULT, cause=01, pc_next=pc_current.
- halt_req:
  - In REQ: takes effect after the current fetch completes, or immediately if no fetch is in flight.
  - Then: go to HALTED, imem_req=0, pc_next=pc_current.
- HALTED:
  - resume=1: go to REQ next cycle.
  - A redirect is accepted (pc_next=target) and the block stays HALTED.
- FAULT: pc_next=pc_current, imem_req=0, instr_valid=0; sticky until reset.
- Priority: reset > fault detection > redirect > halt_req > stall > sequential.
- instr_valid asserted only when imem_req=1 and imem_ready=1 in the same cycle and the fetch is not squashed.
- imem_ready with imem_req=0 is ignored.

Decomposition:
- Shared package fetch_pkg:
  - state enum
  - fault_cause encodings
  - constant INSTR_BYTES=4
- One natural sub-module: fetch_timeout_counter (clear/enable/expired, width TO_W).

Test Plan:
- Reset then imem_ready tied 1 -> pc_next sequence 0,4,8,12; instr_valid=1 from the first REQ cycle.
- Ready delayed 3 cycles at PC 0x10 -> imem_addr=0x10 held 4 cycles, pc_next=0x10 throughout, then 0x14 with a one-cycle instr_valid.
- redirect_target=0x100 during WAIT at PC 0x20, ready 2 cycles later -> instr_valid=0 on completion, pc_next=0x100.
- redirect_target=0x102 -> fault=1, cause=01, imem_req=0 until reset; reset clears fault and pc_next=RESET_VECTOR.
- imem_ready held 0 with TIMEOUT=16 -> FAULT exactly 16 cycles after entering WAIT, cause=10.
- halt_req mid-WAIT -> fetch completes, halted=1, pc_next frozen; resume -> next request at pc_current; stall=1 in REQ -> imem_req=0, pc_next=pc_current.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC fetch sequencer and its timeout counter.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HALTED,
        ST_FAULT
    } fetch_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_TIMEOUT  = 2'b10
    } fault_cause_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts cycles spent waiting on instruction memory; expired flags the last permitted wait cycle.
module fetch_timeout_counter #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TO_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry means this wait cycle is the TIMEOUT-th one and no more are allowed.
    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program-counter / instruction-fetch controller: selects the PC register's next value,
// runs the imem req/ready handshake, and handles halt, redirects and sticky faults.
module pc_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          TIMEOUT      = 16,
    parameter int          TO_W         = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_current,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    input  logic        resume,
    input  logic        imem_ready,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        instr_valid,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    fetch_state_t state_q, state_d;
    fault_cause_t cause_q, cause_d;
    logic         pend_valid_q, pend_valid_d;
    logic [31:0]  pend_target_q, pend_target_d;
    logic         halt_pend_q, halt_pend_d;
    logic         fault_q, fault_d;
    logic         halted_q, halted_d;

    logic        misalign;
    logic        wait_expired;
    logic [31:0] pc_plus4;

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_q != ST_WAIT),
        .enable  (state_q == ST_WAIT),
        .expired (wait_expired)
    );

    assign misalign  = redirect_valid && is_misaligned(redirect_target);
    assign pc_plus4  = pc_current + INSTR_BYTES;
    assign imem_addr = pc_current;

    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        halt_pend_d   = halt_pend_q;
        pc_next       = pc_current;
        imem_req      = 1'b0;
        instr_valid   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pc_next = RESET_VECTOR;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (misalign) begin
                    state_d = ST_FAULT;
                    cause_d = CAUSE_MISALIGN;
                end else if (redirect_valid) begin
                    // Any same-cycle response belongs to the squashed path.
                    imem_req = !stall;
                    pc_next  = redirect_target;
                end else if (halt_req) begin
                    state_d = ST_HALTED;
                end else if (!stall) begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        instr_valid = 1'b1;
                        pc_next     = pc_plus4;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                imem_req = 1'b1;
                if (misalign) begin
                    imem_req = 1'b0;
                    state_d  = ST_FAULT;
                    cause_d  = CAUSE_MISALIGN;
                end else if (imem_ready) begin
                    state_d      = (halt_pend_q || halt_req) ? ST_HALTED : ST_REQ;
                    pend_valid_d = 1'b0;
                    halt_pend_d  = 1'b0;
                    if (redirect_valid) begin
                        pc_next = redirect_target;
                    end else if (pend_valid_q) begin
                        pc_next = pend_target_q;
                    end else begin
                        pc_next     = pc_plus4;
                        instr_valid = 1'b1;
                    end
                end else if (wait_expired) begin
                    state_d = ST_FAULT;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    if (redirect_valid) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = redirect_target;
                    end
                    if (halt_req) begin
                        halt_pend_d = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                if (misalign) begin
                    state_d = ST_FAULT;
                    cause_d = CAUSE_MISALIGN;
                end else if (redirect_valid) begin
                    pc_next = redirect_target;
                end else if (resume) begin
                    state_d = ST_REQ;
                end
            end
            ST_FAULT: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (reset) begin
            state_d       = ST_IDLE;
            cause_d       = CAUSE_NONE;
            pend_valid_d  = 1'b0;
            pend_target_d = '0;
            halt_pend_d   = 1'b0;
            pc_next       = RESET_VECTOR;
            imem_req      = 1'b0;
            instr_valid   = 1'b0;
        end

        fault_d  = (state_d == ST_FAULT);
        halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clock) begin
        state_q       <= state_d;
        cause_q       <= cause_d;
        pend_valid_q  <= pend_valid_d;
        pend_target_q <= pend_target_d;
        halt_pend_q   <= halt_pend_d;
        fault_q       <= fault_d;
        halted_q      <= halted_d;
    end

    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner sequences, and
// randomized traffic against a behavioural model of the fetch rules.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RV      = 32'h0000_0000;
    localparam int          TIMEOUT = 16;

    logic        clock;
    logic        reset;
    logic [31:0] pc_current;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        resume;
    logic        imem_ready;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_cause;

    pc_fetch_sequencer #(
        .RESET_VECTOR (RV),
        .TIMEOUT      (TIMEOUT),
        .TO_W         (5)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pc_current      (pc_current),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .resume          (resume),
        .imem_ready      (imem_ready),
        .pc_next         (pc_next),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .instr_valid     (instr_valid),
        .halted          (halted),
        .fault           (fault),
        .fault_cause     (fault_cause)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] pc_reg   = 32'h0000_1234;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    bit          m_known, m_started, m_busy, m_halted, m_faulted, m_halt_pend;
    int          m_wait;
    logic [31:0] m_pend[$];
    logic [1:0]  m_cause;

    task automatic m_fault(input logic [1:0] c);
        m_faulted = 1; m_cause = c; m_busy = 0; m_halted = 0;
    endtask

    task automatic model_step(input bit r, s, rv, input logic [31:0] rt, input bit h, re, rdy,
                              input logic [31:0] pc, output logic [31:0] e_pc,
                              output bit e_req, output bit e_valid);
        bit bad;
        bad = rv && (rt % 4 != 0);
        e_pc = pc; e_req = 0; e_valid = 0;
        if (r) begin
            e_pc = RV; m_known = 1; m_started = 0; m_busy = 0; m_halted = 0;
            m_faulted = 0; m_halt_pend = 0; m_cause = 0; m_wait = 0; m_pend.delete();
        end else if (!m_started) begin
            e_pc = RV; m_started = 1;
        end else if (m_faulted) begin
            e_pc = pc;
        end else if (m_halted) begin
            if (bad) m_fault(2'b01);
            else if (rv) e_pc = rt;
            else if (re) m_halted = 0;
        end else if (m_busy) begin
            if (bad) m_fault(2'b01);
            else if (rdy) begin
                e_req = 1;
                if (rv) e_pc = rt;
                else if (m_pend.size() > 0) e_pc = m_pend[0];
                else begin e_pc = pc + 4; e_valid = 1; end
                m_busy = 0; m_pend.delete();
                m_halted = m_halt_pend || h; m_halt_pend = 0;
            end else if (m_wait + 1 >= TIMEOUT) begin
                e_req = 1; m_fault(2'b10);
            end else begin
                e_req = 1; m_wait++;
                if (rv) begin m_pend.delete(); m_pend.push_back(rt); end
                if (h) m_halt_pend = 1;
            end
        end else begin
            if (bad) m_fault(2'b01);
            else if (rv) begin e_req = !s; e_pc = rt; end
            else if (h) m_halted = 1;
            else if (!s) begin
                e_req = 1;
                if (rdy) begin e_valid = 1; e_pc = pc + 4; end
                else begin m_busy = 1; m_wait = 0; end
            end
        end
    endtask

    task automatic drive(input bit r, s, rv, input logic [31:0] rt, input bit h, re, rdy);
        @(negedge clock);
        reset = r; stall = s; redirect_valid = rv; redirect_target = rt;
        halt_req = h; resume = re; imem_ready = rdy; pc_current = pc_reg;
        #2;
    endtask

    task automatic step(input bit r, s, rv, input logic [31:0] rt, input bit h, re, rdy);
        logic [31:0] e_pc;
        bit e_req, e_valid, known, e_halt, e_fault;
        logic [1:0] e_cause;
        drive(r, s, rv, rt, h, re, rdy);
        known = m_known; e_halt = m_halted; e_fault = m_faulted; e_cause = m_cause;
        model_step(r, s, rv, rt, h, re, rdy, pc_reg, e_pc, e_req, e_valid);
        chk("pc_next", pc_next, e_pc);
        chk("imem_req", imem_req, e_req);
        chk("instr_valid", instr_valid, e_valid);
        chk("imem_addr", imem_addr, pc_reg);
        if (known) begin
            chk("halted", halted, e_halt);
            chk("fault", fault, e_fault);
            chk("fault_cause", fault_cause, e_cause);
        end
        pc_reg = e_pc;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit r, s, rv; logic [31:0] rt; bit h, re, rdy;
        logic [31:0] e_pc; bit e_req, e_valid, e_halted, e_fault; logic [1:0] e_cause; bit chk_reg;
    } vec_t;

    function automatic vec_t mkv(bit r, s, rv, logic [31:0] rt, bit h, re, rdy,
                                 logic [31:0] e_pc, bit rq, vl, hl, fl, logic [1:0] c, bit cr);
        vec_t v;
        v.r = r; v.s = s; v.rv = rv; v.rt = rt; v.h = h; v.re = re; v.rdy = rdy;
        v.e_pc = e_pc; v.e_req = rq; v.e_valid = vl; v.e_halted = hl; v.e_fault = fl;
        v.e_cause = c; v.chk_reg = cr;
        return v;
    endfunction

    vec_t tbl[$];
    bit   tmo_seen;
    int   k;
    int   drought;

    initial begin
        reset = 1; stall = 0; redirect_valid = 0; redirect_target = 0;
        halt_req = 0; resume = 0; imem_ready = 0; pc_current = pc_reg;
        m_known = 0;

        //             r s rv target        h re rdy  e_pc          rq vl hl fl cause cr
        tbl.push_back(mkv(1,0,0,32'h0,        0,0,1, 32'h0,         0,0,0,0,2'b00,0));
        tbl.push_back(mkv(1,0,0,32'h0,        0,0,1, 32'h0,         0,0,0,0,2'b00,1));
        tbl.push_back(mkv(0,0,0,32'h0,        0,0,1, 32'h0,         0,0,0,0,2'b00,1));
        tbl.push_back(mkv(0,0,0,32'h0,        0,0,1, 32'h4,         1,1,0,0,2'b00,1));
        tbl.push_back(mkv(0,0,0,32'h0,        0,0,1, 32'h8,         1,1,0,0,2'b00,1));
        tbl.push_back(mkv(0,0,0,32'h0,        0,0,1, 32'hC,         1,1,0,0,2'b00,1));
        tbl.push_back(mkv(0,1,0,32'h0,        0,0,1, 32'hC,         0,0,0,0,2'b00,1));
        tbl.push_back(mkv(0,0,1,32'h40,       0,0,1, 32'h40,        1,0,0,0,2'b00,1));
        tbl.push_back(mkv(0,0,0,32'h0,        0,0,1, 32'h44,        1,1,0,0,2'b00,1));
        tbl.push_back(mkv(0,0,0,32'h0,        1,0,1, 32'h44,        0,0,0,0,2'b00,1));
        tbl.push_back(mkv(0,0,0,32'h0,        0,0,1, 32'h44,        0,0,1,0,2'b00,1));
        tbl.push_back(mkv(0,0,1,32'hFFFF_FFFC,0,0,1, 32'hFFFF_FFFC, 0,0,1,0,2'b00,1));
        tbl.push_back(mkv(0,0,0,32'h0,        0,1,1, 32'hFFFF_FFFC, 0,0,1,0,2'b00,1));
        tbl.push_back(mkv(0,0,0,32'h0,        0,0,1, 32'h0,         1,1,0,0,2'b00,1));
        tbl.push_back(mkv(0,0,1,32'h3,        0,0,1, 32'h0,         0,0,0,0,2'b00,1));
        tbl.push_back(mkv(0,0,0,32'h0,        0,0,1, 32'h0,         0,0,0,1,2'b01,1));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].rv, tbl[i].rt, tbl[i].h, tbl[i].re, tbl[i].rdy);
            $display("vec %0d: pc_cur=%h pc_next=%h req=%0b valid=%0b halted=%0b fault=%0b cause=%0d",
                     i, pc_reg, pc_next, imem_req, instr_valid, halted, fault, fault_cause);
            chk($sformatf("vec%0d.pc_next", i), pc_next, tbl[i].e_pc);
            chk($sformatf("vec%0d.imem_req", i), imem_req, tbl[i].e_req);
            chk($sformatf("vec%0d.instr_valid", i), instr_valid, tbl[i].e_valid);
            if (tbl[i].chk_reg) begin
                chk($sformatf("vec%0d.halted", i), halted, tbl[i].e_halted);
                chk($sformatf("vec%0d.fault", i), fault, tbl[i].e_fault);
                chk($sformatf("vec%0d.cause", i), fault_cause, tbl[i].e_cause);
            end
            pc_reg = tbl[i].e_pc;
        end

        // Ready delayed 3 cycles at 0x10.
        step(1,0,0,0,0,0,0);
        step(0,0,0,0,0,0,0);
        step(0,0,1,32'h10,0,0,0);
        for (int i = 0; i < 4; i++) begin
            step(0,0,0,0,0,0,(i == 3));
            chk("delay.addr", imem_addr, 32'h10);
            chk("delay.pc_next", pc_next, (i == 3) ? 32'h14 : 32'h10);
            chk("delay.valid", instr_valid, (i == 3) ? 32'd1 : 32'd0);
        end
        $display("seq delayed-ready done at pc %h", pc_reg);

        // Redirect latched during WAIT.
        step(0,0,1,32'h20,0,0,0);
        step(0,0,0,0,0,0,0);
        step(0,0,1,32'h100,0,0,0);
        step(0,0,0,0,0,0,0);
        step(0,0,0,0,0,0,1);
        chk("wait_redir.valid", instr_valid, 32'd0);
        chk("wait_redir.pc_next", pc_next, 32'h100);
        $display("seq wait-redirect done at pc %h", pc_reg);

        // Misaligned redirect -> sticky fault until reset.
        step(0,0,1,32'h102,0,0,1);
        for (int i = 0; i < 3; i++) begin
            step(0,0,0,0,0,0,1);
            chk("misalign.fault", fault, 32'd1);
            chk("misalign.cause", fault_cause, 32'd1);
            chk("misalign.req", imem_req, 32'd0);
        end
        step(1,0,0,0,0,0,0);
        chk("fault_reset.pc_next", pc_next, RV);
        step(0,0,0,0,0,0,0);
        chk("fault_reset.fault", fault, 32'd0);
        chk("fault_reset.cause", fault_cause, 32'd0);
        $display("seq misaligned-fault done");

        // Timeout with ready held low.
        step(0,0,0,0,0,0,0);
        k = 0; tmo_seen = 0;
        for (int i = 0; i < 40 && !tmo_seen; i++) begin
            step(0,0,0,0,0,0,0);
            if (fault) tmo_seen = 1; else k++;
        end
        chk("timeout.seen", tmo_seen, 32'd1);
        chk("timeout.cycles", k, TIMEOUT);
        chk("timeout.cause", fault_cause, 32'd2);
        $display("seq timeout: fault after %0d wait cycles", k);

        // Halt mid-WAIT, resume, stall.
        step(1,0,0,0,0,0,0);
        step(0,0,0,0,0,0,0);
        step(0,0,0,0,0,0,0);
        step(0,0,0,0,1,0,0);
        step(0,0,0,0,0,0,1);
        chk("halt.complete_valid", instr_valid, 32'd1);
        step(0,0,0,0,0,0,1);
        chk("halt.halted", halted, 32'd1);
        chk("halt.pc_frozen", pc_next, 32'h4);
        chk("halt.req", imem_req, 32'd0);
        step(0,0,0,0,0,1,0);
        step(0,0,0,0,0,0,1);
        chk("resume.req", imem_req, 32'd1);
        chk("resume.addr", imem_addr, 32'h4);
        step(0,1,0,0,0,0,1);
        chk("stall.req", imem_req, 32'd0);
        chk("stall.pc_next", pc_next, 32'h8);
        $display("seq halt-resume-stall done at pc %h", pc_reg);

        // Randomized traffic against the model.
        step(1,0,0,0,0,0,0);
        drought = 0;
        for (int i = 0; i < 4000; i++) begin
            bit r, s, rv, h, re, rdy;
            logic [31:0] rt;
            r  = ($urandom_range(0, 149) == 0);
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 5) == 0);
            rt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 29) == 0) rt[1:0] = 2'($urandom_range(1, 3));
            h  = ($urandom_range(0, 19) == 0);
            re = ($urandom_range(0, 3) == 0);
            if (drought == 0 && $urandom_range(0, 99) == 0) drought = $urandom_range(10, 24);
            if (drought > 0) begin rdy = 0; drought--; end
            else rdy = 1'($urandom_range(0, 1));
            step(r, s, rv, rt, h, re, rdy);
        end
        $display("random phase done: %0d checks so far", n_checks);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
